// File: rtl/screen_sequencer_pkg.sv
// Shared types and constants for the screen sequencer slice.
// Holds the sequencer state encoding, the VGA coordinate widths, the default
// colour width and the transparent colour key used by the optional key-out path.
package screen_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAW,
      ST_FLUSH,
      ST_HOLD,
      ST_DONE
   } state_t;

   localparam int VGA_X_W          = 8;
   localparam int VGA_Y_W          = 7;
   localparam int COLOUR_W_DEFAULT = 9;

   // Transparent key: this bit replicated across the full colour width
   // (all-ones), so the key tracks whatever COLOUR_W the block is built with.
   localparam logic TRANSPARENT_KEY_BIT = 1'b1;

   // Synchronous ROM read plus the output register stage.
   localparam int FLUSH_CYCLES = 2;

endpackage

// File: rtl/screen_sequencer_if.sv
// Bundle of all non-clock signals of the screen sequencer.
// master: sequencer side (drives ROM address/select, VGA plot bus, done, busy).
// slave : environment side (drives req and the ROM read data).
interface screen_sequencer_if
   import screen_sequencer_pkg::*;
#(
   parameter int NUM_SCREENS = 9,
   parameter int H_RES       = 160,
   parameter int V_RES       = 120,
   parameter int COLOUR_W    = COLOUR_W_DEFAULT
);
   localparam int SEL_W  = $clog2(NUM_SCREENS);
   localparam int ADDR_W = $clog2(H_RES * V_RES);

   // request / completion channels
   logic [NUM_SCREENS-1:0] req;
   logic [NUM_SCREENS-1:0] done;
   logic                   busy;

   // image ROM port (rom_data valid one cycle after rom_addr)
   logic [SEL_W-1:0]       rom_sel;
   logic [ADDR_W-1:0]      rom_addr;
   logic [COLOUR_W-1:0]    rom_data;

   // VGA plot port
   logic [VGA_X_W-1:0]     x;
   logic [VGA_Y_W-1:0]     y;
   logic [COLOUR_W-1:0]    colour;
   logic                   write_en;

   modport master (
      input  req, rom_data,
      output done, busy, rom_sel, rom_addr, x, y, colour, write_en
   );

   modport slave (
      output req, rom_data,
      input  done, busy, rom_sel, rom_addr, x, y, colour, write_en
   );

endinterface

// File: rtl/screen_sequencer_req_arbiter.sv
// Request arming and fixed-priority grant for the screen sequencer.
// Ports: clk, resetn, req (level per screen), disarm_en/disarm_idx (channel just
// completed), grant_idx/grant_vld (lowest-index request that is armed).
// Latency: grant is combinational from req and the registered arm mask.
module screen_req_arbiter
#(
   parameter int NUM_SCREENS = 9,
   parameter int SEL_W       = $clog2(NUM_SCREENS)
)(
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NUM_SCREENS-1:0] req,
   input  logic                   disarm_en,
   input  logic [SEL_W-1:0]       disarm_idx,
   output logic [SEL_W-1:0]       grant_idx,
   output logic                   grant_vld
);

   logic [NUM_SCREENS-1:0] arm;
   logic [NUM_SCREENS-1:0] disarm_mask;

   always_comb begin
      disarm_mask = '0;
      if (disarm_en) begin
         disarm_mask[disarm_idx] = 1'b1;
      end
   end

   // A channel re-arms only once its req has been seen low, so a request
   // that simply stays high after completing is not served a second time.
   // Disarm wins in the completion cycle; a low req re-arms one cycle later.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         arm <= '1;
      end else begin
         arm <= (arm | ~req) & ~disarm_mask;
      end
   end

   // Scan high to low so the last hit (lowest index) wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = NUM_SCREENS - 1; i >= 0; i--) begin
         if (req[i] && arm[i]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/screen_sequencer.sv
// Copies one of NUM_SCREENS ROM images onto a VGA plot port, one pixel per cycle.
// Latency: a pixel is plotted (write_en=1) 2 cycles after its rom_addr; done
// pulses 1 + HOLD_CYCLES cycles after the last plotted pixel.
// Backpressure: none; the plot port always accepts. Dropping req[sel] during
// DRAW/HOLD aborts the frame within one cycle, squashing in-flight pixels.
// Ports: clk, resetn, bus (screen_sequencer_if.master: req/done/busy, ROM port,
// VGA port). Build option: define SCREEN_TRANSPARENT_EN to skip plotting pixels
// whose ROM colour is all-ones.
module screen_sequencer
   import screen_sequencer_pkg::*;
#(
   parameter int NUM_SCREENS = 9,
   parameter int H_RES       = 160,
   parameter int V_RES       = 120,
   parameter int COLOUR_W    = COLOUR_W_DEFAULT,
   parameter int HOLD_CYCLES = 0
)(
   input  logic               clk,
   input  logic               resetn,
   screen_sequencer_if.master bus
);

   localparam int SEL_W     = $clog2(NUM_SCREENS);
   localparam int ADDR_W    = $clog2(H_RES * V_RES);
   localparam int HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int FLUSH_W   = 1;

`ifdef SCREEN_TRANSPARENT_EN
   localparam bit KEY_EN = 1'b1;
`else
   localparam bit KEY_EN = 1'b0;
`endif

   state_t                  state, state_nxt;
   logic [SEL_W-1:0]        sel_q;
   logic [ADDR_W-1:0]       addr_cnt;
   logic [VGA_X_W-1:0]      x_cnt;
   logic [VGA_Y_W-1:0]      y_cnt;
   logic [FLUSH_W-1:0]      flush_cnt;
   logic [HOLD_W-1:0]       hold_cnt;

   // stage 1: coordinates travelling alongside the ROM read
   logic                    pix_vld_s1;
   logic [VGA_X_W-1:0]      x_s1;
   logic [VGA_Y_W-1:0]      y_s1;

   // stage 2: registered VGA outputs
   logic                    write_en_q;
   logic [VGA_X_W-1:0]      x_q;
   logic [VGA_Y_W-1:0]      y_q;
   logic [COLOUR_W-1:0]     colour_q;

   logic [SEL_W-1:0]        grant_idx;
   logic                    grant_vld;
   logic                    abort;
   logic                    last_addr;
   logic                    key_hit;
   logic                    pix_plot;
   logic [NUM_SCREENS-1:0]  done_vec;

   screen_req_arbiter #(
      .NUM_SCREENS (NUM_SCREENS),
      .SEL_W       (SEL_W)
   ) u_arb (
      .clk        (clk),
      .resetn     (resetn),
      .req        (bus.req),
      .disarm_en  (state == ST_DONE),
      .disarm_idx (sel_q),
      .grant_idx  (grant_idx),
      .grant_vld  (grant_vld)
   );

   // Only DRAW and HOLD are abortable; FLUSH always drains to completion.
   assign abort     = ((state == ST_DRAW) || (state == ST_HOLD)) && !bus.req[sel_q];
   assign last_addr = (addr_cnt == ADDR_W'(H_RES * V_RES - 1));
   assign key_hit   = KEY_EN && (bus.rom_data == {COLOUR_W{TRANSPARENT_KEY_BIT}});
   assign pix_plot  = pix_vld_s1 && !abort && !key_hit;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      done_vec  = '0;
      case (state)
         ST_IDLE: begin
            if (grant_vld) begin
               state_nxt = ST_DRAW;
            end
         end
         ST_DRAW: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (last_addr) begin
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt == FLUSH_W'(FLUSH_CYCLES - 1)) begin
               state_nxt = (HOLD_CYCLES == 0) ? ST_DONE : ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done_vec[sel_q] = 1'b1;
            state_nxt       = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------- counters and selection ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sel_q     <= '0;
         addr_cnt  <= '0;
         x_cnt     <= '0;
         y_cnt     <= '0;
         flush_cnt <= '0;
         hold_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               addr_cnt  <= '0;
               x_cnt     <= '0;
               y_cnt     <= '0;
               flush_cnt <= '0;
               hold_cnt  <= '0;
               if (grant_vld) begin
                  sel_q <= grant_idx;
               end
            end
            ST_DRAW: begin
               // rom_addr parks on the last pixel while the pipeline drains.
               if (!abort && !last_addr) begin
                  addr_cnt <= addr_cnt + ADDR_W'(1);
                  if (x_cnt == VGA_X_W'(H_RES - 1)) begin
                     x_cnt <= '0;
                     y_cnt <= y_cnt + VGA_Y_W'(1);
                  end else begin
                     x_cnt <= x_cnt + VGA_X_W'(1);
                  end
               end
            end
            ST_FLUSH: flush_cnt <= flush_cnt + FLUSH_W'(1);
            ST_HOLD:  hold_cnt  <= hold_cnt + HOLD_W'(1);
            default: ;
         endcase
      end
   end

   // ---------------- pixel pipeline ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pix_vld_s1 <= 1'b0;
         x_s1       <= '0;
         y_s1       <= '0;
         write_en_q <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         colour_q   <= '0;
      end else begin
         pix_vld_s1 <= (state == ST_DRAW) && !abort;
         x_s1       <= x_cnt;
         y_s1       <= y_cnt;
         write_en_q <= pix_plot;
         // VGA bus holds its last plotted value outside plot cycles.
         if (pix_plot) begin
            x_q      <= x_s1;
            y_q      <= y_s1;
            colour_q <= bus.rom_data;
         end
      end
   end

   assign bus.rom_sel  = sel_q;
   assign bus.rom_addr = addr_cnt;
   assign bus.x        = x_q;
   assign bus.y        = y_q;
   assign bus.colour   = colour_q;
   assign bus.write_en = write_en_q;
   assign bus.done     = done_vec;
   assign bus.busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboard bench for screen_sequencer: stimulus pushes expected pixels/done
// pulses (with their cycle numbers) into queues, a negedge monitor pops and
// compares whenever write_en or done is seen. A second instance with
// HOLD_CYCLES=50 runs alongside the first frame.
module tb_screen_sequencer;

   localparam int NPIX = 160 * 120;

`ifdef SCREEN_TRANSPARENT_EN
   localparam int       T1_WRITES = NPIX / 2;
   localparam int       T1_LAST_X = 158;
   localparam bit [8:0] T1_LAST_C = 9'h0A5;
`else
   localparam int       T1_WRITES = NPIX;
   localparam int       T1_LAST_X = 159;
   localparam bit [8:0] T1_LAST_C = 9'h1FF;
`endif

   typedef struct {int x; int y; int c; int t;} pix_t;
   typedef struct {int idx; int t;} dn_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   wr_cnt = 0;

   pix_t exp_q[$];
   dn_t  done_q[$];
   pix_t e_pix;
   dn_t  e_dn;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   screen_sequencer_if #(.NUM_SCREENS(9), .H_RES(160), .V_RES(120), .COLOUR_W(9)) bus   ();
   screen_sequencer_if #(.NUM_SCREENS(9), .H_RES(160), .V_RES(120), .COLOUR_W(9)) bus_h ();

   screen_sequencer #(.NUM_SCREENS(9), .H_RES(160), .V_RES(120), .COLOUR_W(9), .HOLD_CYCLES(0))
      u_dut (.clk(clk), .resetn(resetn), .bus(bus));

   screen_sequencer #(.NUM_SCREENS(9), .H_RES(160), .V_RES(120), .COLOUR_W(9), .HOLD_CYCLES(50))
      u_hold (.clk(clk), .resetn(resetn), .bus(bus_h));

   // Image content: screen 3 alternates written/key colours, the rest encode
   // screen number and low address bits (never all-ones).
   function automatic logic [8:0] rom_f(input int sel, input int addr);
      logic [31:0] a;
      logic [31:0] s;
      a = addr;
      s = sel;
      if (sel == 3) return a[0] ? 9'h1FF : 9'h0A5;
      return {s[3:0], a[4:0]};
   endfunction

   function automatic bit is_key(input logic [8:0] c);
`ifdef SCREEN_TRANSPARENT_EN
      return (c == 9'h1FF);
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk) bus.rom_data   <= rom_f(int'(bus.rom_sel), int'(bus.rom_addr));
   always @(posedge clk) bus_h.rom_data <= rom_f(int'(bus_h.rom_sel), int'(bus_h.rom_addr));

   // g = edge at which IDLE grants; pixel i is plotted in the cycle after edge g+2+i.
   task automatic push_frame(input int sel, input int g, input int npix);
      logic [8:0] c;
      for (int i = 0; i < npix; i++) begin
         c = rom_f(sel, i);
         if (!is_key(c)) exp_q.push_back('{i % 160, i / 160, int'(c), g + 2 + i});
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string name);
      check(name, {bus.write_en, bus.done, bus.busy, bus.x, bus.y, bus.colour,
                   bus.rom_sel, bus.rom_addr}, 64'd0);
   endtask

   // Called at #1 after an edge; returns at #1 after edge n.
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (resetn) begin
         if (bus.write_en) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pixel_unexpected got (%0d,%0d) colour=%h cycle=%0d want none",
                        bus.x, bus.y, bus.colour, cyc);
            end else begin
               e_pix = exp_q.pop_front();
               if (bus.x !== 8'(e_pix.x) || bus.y !== 7'(e_pix.y) ||
                   bus.colour !== 9'(e_pix.c) || cyc != e_pix.t) begin
                  errors++;
                  $display("FAIL pixel got (%0d,%0d) colour=%h cycle=%0d want (%0d,%0d) colour=%h cycle=%0d",
                           bus.x, bus.y, bus.colour, cyc, e_pix.x, e_pix.y, e_pix.c, e_pix.t);
               end
            end
         end
         if (bus.done != '0) begin
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected got %b cycle=%0d want none", bus.done, cyc);
            end else begin
               e_dn = done_q.pop_front();
               if (bus.done !== (9'd1 << e_dn.idx) || cyc != e_dn.t) begin
                  errors++;
                  $display("FAIL done got %b cycle=%0d want %b cycle=%0d",
                           bus.done, cyc, 9'd1 << e_dn.idx, e_dn.t);
               end
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "bench did not finish");
   end

   // ---------------- stimulus ----------------
   initial begin
      int k, g, g2, g3, g4, r;
      bus.req   = '0;
      bus_h.req = '0;
      resetn    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_outputs");
      resetn = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_zero("idle_outputs");

      // ---- screen 3 held high; HOLD instance draws screen 0 alongside ----
      k = cyc;
      g = k + 1;
      wr_cnt = 0;
      bus.req[3]   = 1'b1;
      bus_h.req[0] = 1'b1;
      push_frame(3, g, NPIX);
      done_q.push_back('{3, g + NPIX + 2});
      fork
         begin
            goto(g + NPIX + 102);
            check("t1_writes", wr_cnt, T1_WRITES);
            check("t1_no_redraw_busy", bus.busy, 1'b0);
            check("t1_hold_x", bus.x, T1_LAST_X);
            check("t1_hold_y", bus.y, 119);
            check("t1_hold_colour", bus.colour, T1_LAST_C);
            bus.req[3] = 1'b0;
            @(posedge clk); #1;
            bus.req[3] = 1'b1;
            @(posedge clk); #1;
            check("t1_rearm_busy", bus.busy, 1'b1);
            bus.req[3] = 1'b0;
            @(posedge clk); #1;
            check("t1_abort_busy", bus.busy, 1'b0);
         end
         begin
            int hcnt, hfirst, hlast, hdone;
            logic [8:0] hdv;
            hcnt = 0; hfirst = -1; hlast = -1; hdone = -1; hdv = '0;
            for (int n = 0; n < NPIX + 200 && hdone < 0; n++) begin
               @(negedge clk);
               if (bus_h.write_en) begin
                  if (hfirst < 0) hfirst = cyc;
                  hcnt++;
                  hlast = cyc;
               end
               if (bus_h.done != '0) begin
                  hdone = cyc;
                  hdv = bus_h.done;
               end
            end
            check("hold_done_seen", (hdone >= 0), 1'b1);
            check("hold_done_vec", hdv, 9'd1);
            check("hold_writes", hcnt, NPIX);
            check("hold_first_cycle", hfirst, g + 2);
            // 50 quiet cycles separate the last plot and the done pulse
            check("hold_gap", hdone - hlast - 1, 50);
            bus_h.req[0] = 1'b0;
         end
      join

      // ---- screens 2 and 4 together, then screen 1 arriving mid-draw ----
      k  = cyc;
      g  = k + 1;
      g2 = g + NPIX + 4;
      g3 = g2 + NPIX + 4;
      bus.req = 9'b000010100;
      push_frame(2, g, NPIX);
      done_q.push_back('{2, g + NPIX + 2});
      push_frame(4, g2, NPIX);
      done_q.push_back('{4, g2 + NPIX + 2});
      goto(g2 + 1000);
      bus.req[1] = 1'b1;
      check("t2_no_preempt_sel", bus.rom_sel, 4);
      push_frame(1, g3, 501);
      goto(g3 + 10);
      check("t3_sel", bus.rom_sel, 1);
      bus.req = 9'b000000010;

      // ---- screen 1 dropped while pixel 500 is on the bus ----
      goto(g3 + 502);
      bus.req[1] = 1'b0;
      goto(g3 + 503);
      check("t3_we_squash", bus.write_en, 1'b0);
      check("t3_busy", bus.busy, 1'b0);
      goto(g3 + 505);
      bus.req[1] = 1'b1;
      g4 = g3 + 506;
      push_frame(1, g4, 4);
      goto(g4 + 5);
      bus.req[1] = 1'b0;
      goto(g4 + 8);
      check("t3_restart_busy", bus.busy, 1'b0);

      // ---- reset in the middle of a frame ----
      k = cyc;
      g = k + 1;
      bus.req = 9'b000000100;
      push_frame(2, g, 99);
      goto(g + 101);
      resetn = 1'b0;
      #1;
      check_zero("reset_mid_frame");
      check("reset_queue_drained", exp_q.size(), 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      r = cyc;
      push_frame(2, r + 1, 10);
      goto(r + 12);
      bus.req = '0;
      goto(r + 15);
      check("reset_redraw_busy", bus.busy, 1'b0);

      goto(cyc + 5);
      check("pixel_queue_empty", exp_q.size(), 0);
      check("done_queue_empty", done_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
